// File: rtl/banked_imem_pkg.sv
// Shared constants and types for the banked instruction memory.
// Holds the power-state encoding, the NOP filler word and the bank geometry.
package imem_pkg;

  typedef enum logic [1:0] {
    PWR_ACTIVE  = 2'd0,
    PWR_STANDBY = 2'd1,
    PWR_DEEP    = 2'd2,
    PWR_WAKE    = 2'd3
  } pwr_state_e;

  localparam logic [31:0] NOP_INSN   = 32'h0000_0013;
  localparam int          BANK_WORDS = 16384;
  localparam int          WORD_AW    = 14;
  localparam int          BANK_LSB   = 16;

  // Width of the bank index; a single bank still gets one (always-zero) bit.
  function automatic int bank_idx_w(input int num_banks);
    return (num_banks <= 1) ? 1 : $clog2(num_banks);
  endfunction

endpackage

// File: rtl/spram_wrap.sv
// Behavioural 16K x 16 single-port RAM wrapper with light/deep sleep requests.
// Reads are registered; sleep requests block access but retain contents.
module spram_wrap
  import imem_pkg::*;
(
  input  logic               clk,
  input  logic               sel,
  input  logic               we,
  input  logic [1:0]         be,
  input  logic [WORD_AW-1:0] addr,
  input  logic [15:0]        din,
  input  logic               ls_req,
  input  logic               ds_req,
  output logic [15:0]        dout
);

  logic [15:0] mem [BANK_WORDS];
  logic [15:0] dout_q;
  logic        access;

  assign access = sel && !ls_req && !ds_req;

  always_ff @(posedge clk) begin
    if (access && we) begin
      if (be[0]) mem[addr][7:0]  <= din[7:0];
      if (be[1]) mem[addr][15:8] <= din[15:8];
    end
    if (access && !we) begin
      dout_q <= mem[addr];
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/banked_imem.sv
// Banked read-only instruction memory with ACTIVE/STANDBY/DEEP/WAKE power sequencing.
// One-cycle fetch latency; out-of-range banks return a NOP with an err pulse.
//
// state   | meaning
// ACTIVE  | fetches accepted, all RAMs awake
// STANDBY | core in WFI, RAMs in light sleep, idle timer running
// DEEP    | idle timer expired, RAMs in deep sleep
// WAKE    | RAMs released from sleep, waiting before fetches resume
module banked_imem
  import imem_pkg::*;
#(
  parameter int NUM_BANKS      = 2,
  parameter int WAKE_CYCLES    = 3,
  parameter int DS_IDLE_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic        wfi,
  input  logic        irq_wake,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err,
  output logic [1:0]  pwr_state
);

  localparam int             BANK_W    = bank_idx_w(NUM_BANKS);
  localparam logic [9:0]     IDLE_LAST = 10'(DS_IDLE_CYCLES - 1);
  localparam logic [3:0]     WAKE_LOAD = 4'(WAKE_CYCLES - 1);

  pwr_state_e        state_q;
  logic [9:0]        idle_cnt_q;
  logic [3:0]        wake_cnt_q;
  logic              wake_cond;

  logic              accept;
  logic              oor;
  logic [BANK_W-1:0] bank_idx;
  logic [WORD_AW-1:0] word_idx;
  logic [NUM_BANKS-1:0] bank_sel;
  logic              ls_req;
  logic              ds_req;
  logic [15:0]       dout_hi [NUM_BANKS];
  logic [15:0]       dout_lo [NUM_BANKS];

  logic              rvalid_q;
  logic              err_q;
  logic              have_q;
  logic              oor_q;
  logic [BANK_W-1:0] bank_q;
  logic              unused_addr;

  assign unused_addr = ^addr[1:0];

  assign ready     = (state_q == PWR_ACTIVE);
  assign pwr_state = state_q;
  assign ls_req    = (state_q == PWR_STANDBY);
  assign ds_req    = (state_q == PWR_DEEP);
  assign wake_cond = !wfi || irq_wake;

  assign accept   = req && ready && !rst;
  assign word_idx = addr[BANK_LSB-1:2];
  assign oor      = ({16'd0, addr[31:BANK_LSB]} >= 32'(NUM_BANKS));
  assign bank_idx = (NUM_BANKS == 1) ? '0 : addr[BANK_LSB +: BANK_W];

  always_comb begin
    bank_sel = '0;
    if (accept && !oor) bank_sel[bank_idx] = 1'b1;
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    spram_wrap u_hi (
      .clk    (clk),
      .sel    (bank_sel[b]),
      .we     (1'b0),
      .be     (2'b00),
      .addr   (word_idx),
      .din    (16'h0000),
      .ls_req (ls_req),
      .ds_req (ds_req),
      .dout   (dout_hi[b])
    );
    spram_wrap u_lo (
      .clk    (clk),
      .sel    (bank_sel[b]),
      .we     (1'b0),
      .be     (2'b00),
      .addr   (word_idx),
      .din    (16'h0000),
      .ls_req (ls_req),
      .ds_req (ds_req),
      .dout   (dout_lo[b])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      have_q   <= 1'b0;
      oor_q    <= 1'b0;
      bank_q   <= '0;
    end else begin
      rvalid_q <= accept;
      err_q    <= accept && oor;
      if (accept) begin
        have_q <= 1'b1;
        oor_q  <= oor;
        bank_q <= bank_idx;
      end
    end
  end

  // RAM outputs only change on a select, so the mux alone holds rdata between fetches.
  always_comb begin
    rdata = '0;
    if (have_q) rdata = oor_q ? NOP_INSN : {dout_hi[bank_q], dout_lo[bank_q]};
  end

  assign rvalid = rvalid_q;
  assign err    = err_q;

  // Wake requests win over the deep-sleep timer expiring in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PWR_ACTIVE;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
    end else begin
      unique case (state_q)
        PWR_ACTIVE: begin
          if (wfi && !irq_wake && !accept) begin
            state_q    <= PWR_STANDBY;
            idle_cnt_q <= '0;
          end
        end
        PWR_STANDBY: begin
          if (wake_cond) begin
            state_q    <= PWR_WAKE;
            wake_cnt_q <= '0;
          end else if (idle_cnt_q == IDLE_LAST) begin
            state_q <= PWR_DEEP;
          end else begin
            idle_cnt_q <= idle_cnt_q + 10'd1;
          end
        end
        PWR_DEEP: begin
          if (wake_cond) begin
            state_q    <= PWR_WAKE;
            wake_cnt_q <= WAKE_LOAD;
          end
        end
        PWR_WAKE: begin
          if (wake_cnt_q == 4'd0) state_q <= PWR_ACTIVE;
          else                    wake_cnt_q <= wake_cnt_q - 4'd1;
        end
        default: state_q <= PWR_ACTIVE;
      endcase
    end
  end

endmodule

// File: tb/tb_banked_imem.sv
// Directed bench for banked_imem: fetch path, out-of-range, power sequencing, reset.
// Two instances share stimulus: default parameters and a short deep-sleep timer.
module tb_banked_imem;

  logic        clk = 1'b0;
  logic        rst, req, wfi, irq_wake;
  logic [31:0] addr;
  logic        ready, rvalid, err;
  logic [31:0] rdata;
  logic [1:0]  pwr_state;
  logic        d_ready, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic [1:0]  d_pwr_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  banked_imem dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .wfi(wfi), .irq_wake(irq_wake),
    .ready(ready), .rvalid(rvalid), .rdata(rdata), .err(err), .pwr_state(pwr_state)
  );

  banked_imem #(.NUM_BANKS(2), .WAKE_CYCLES(3), .DS_IDLE_CYCLES(8)) dut_d (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .wfi(wfi), .irq_wake(irq_wake),
    .ready(d_ready), .rvalid(d_rvalid), .rdata(d_rdata), .err(d_err), .pwr_state(d_pwr_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1; req = 1'b0; wfi = 1'b0; irq_wake = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic preload();
    dut.g_bank[0].u_hi.mem[5]   = 16'hDEAD;  dut.g_bank[0].u_lo.mem[5]   = 16'hBEEF;
    dut.g_bank[1].u_hi.mem[0]   = 16'h1234;  dut.g_bank[1].u_lo.mem[0]   = 16'h5678;
    dut.g_bank[0].u_hi.mem[0]   = 16'hCAFE;  dut.g_bank[0].u_lo.mem[0]   = 16'hF00D;
    dut_d.g_bank[0].u_hi.mem[5] = 16'hDEAD;  dut_d.g_bank[0].u_lo.mem[5] = 16'hBEEF;
    dut_d.g_bank[1].u_hi.mem[0] = 16'h1234;  dut_d.g_bank[1].u_lo.mem[0] = 16'h5678;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b1; addr = 32'h14; wfi = 1'b0; irq_wake = 1'b0;
    tick();
    tick();
    checks++; if (pwr_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", pwr_state); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b exp 0", rvalid); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 00000000", rdata); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready); end
    checks++; if (dut.idle_cnt_q !== 10'd0) begin errors++; $display("FAIL reset_idle_cnt got %0d exp 0", dut.idle_cnt_q); end
    checks++; if (dut.wake_cnt_q !== 4'd0) begin errors++; $display("FAIL reset_wake_cnt got %0d exp 0", dut.wake_cnt_q); end
    checks++; if (dut.ls_req !== 1'b0 || dut.ds_req !== 1'b0) begin errors++; $display("FAIL reset_sleep_req got %b%b exp 00", dut.ls_req, dut.ds_req); end
    rst = 1'b0; req = 1'b0;
    tick();
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_discard got %b exp 0", rvalid); end
  endtask

  task automatic test_back_to_back();
    req = 1'b1; addr = 32'h0000_0014;
    tick();
    checks++; if (rvalid !== 1'b1 || rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_first got v=%b %h exp v=1 deadbeef", rvalid, rdata); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL b2b_first_err got %b exp 0", err); end
    addr = 32'h0001_0000;
    tick();
    checks++; if (rvalid !== 1'b1 || rdata !== 32'h12345678) begin errors++; $display("FAIL b2b_second got v=%b %h exp v=1 12345678", rvalid, rdata); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL b2b_second_err got %b exp 0", err); end
    req = 1'b0;
    tick();
    checks++; if (rvalid !== 1'b0 || rdata !== 32'h12345678) begin errors++; $display("FAIL b2b_hold got v=%b %h exp v=0 12345678", rvalid, rdata); end
  endtask

  task automatic test_out_of_range();
    req = 1'b1; addr = 32'h0001_000C;
    #1;
    checks++; if (dut.bank_sel !== 2'b10) begin errors++; $display("FAIL sel_onehot got %b exp 10", dut.bank_sel); end
    addr = 32'h0002_0000;
    #1;
    checks++; if (dut.bank_sel !== 2'b00) begin errors++; $display("FAIL oor_sel got %b exp 00", dut.bank_sel); end
    tick();
    checks++; if (rvalid !== 1'b1 || rdata !== 32'h00000013 || err !== 1'b1) begin errors++; $display("FAIL oor_resp got v=%b %h e=%b exp v=1 00000013 e=1", rvalid, rdata, err); end
    req = 1'b0;
    tick();
    checks++; if (err !== 1'b0 || rvalid !== 1'b0) begin errors++; $display("FAIL oor_pulse got e=%b v=%b exp e=0 v=0", err, rvalid); end
    checks++; if (rdata !== 32'h00000013) begin errors++; $display("FAIL oor_hold got %h exp 00000013", rdata); end
  endtask

  task automatic test_standby();
    int bad = 0;
    wfi = 1'b1; req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      req = 1'b1; addr = 32'h14;
      if (pwr_state !== 2'd1 || ready !== 1'b0 || rvalid !== 1'b0 || dut.ls_req !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL standby_hold got %0d bad cycles exp 0", bad); end
    wfi = 1'b0; req = 1'b0;
    tick();
    checks++; if (pwr_state !== 2'd3 || ready !== 1'b0) begin errors++; $display("FAIL standby_wake got st=%0d rdy=%b exp st=3 rdy=0", pwr_state, ready); end
    tick();
    checks++; if (pwr_state !== 2'd0 || ready !== 1'b1) begin errors++; $display("FAIL standby_active got st=%0d rdy=%b exp st=0 rdy=1", pwr_state, ready); end
  endtask

  task automatic test_wfi_fetch();
    req = 1'b1; addr = 32'h0; wfi = 1'b1;
    tick();
    checks++; if (rvalid !== 1'b1 || rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL wfi_fetch_data got v=%b %h exp v=1 cafef00d", rvalid, rdata); end
    checks++; if (pwr_state !== 2'd0) begin errors++; $display("FAIL wfi_fetch_defer got %0d exp 0", pwr_state); end
    req = 1'b0;
    tick();
    checks++; if (pwr_state !== 2'd1 || rvalid !== 1'b0) begin errors++; $display("FAIL wfi_fetch_standby got st=%0d v=%b exp st=1 v=0", pwr_state, rvalid); end
    wfi = 1'b0;
    tick();
    tick();
    checks++; if (pwr_state !== 2'd0) begin errors++; $display("FAIL wfi_fetch_return got %0d exp 0", pwr_state); end
  endtask

  task automatic go_deep();
    int bad = 0;
    wfi = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (d_pwr_state !== 2'd1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL deep_standby_len got %0d bad cycles exp 0", bad); end
    tick();
    checks++; if (d_pwr_state !== 2'd2) begin errors++; $display("FAIL deep_entry got %0d exp 2", d_pwr_state); end
  endtask

  task automatic test_deep();
    int bad = 0;
    pulse_reset();
    go_deep();
    tick();
    checks++; if (d_pwr_state !== 2'd2 || dut_d.ds_req !== 1'b1 || dut_d.ls_req !== 1'b0) begin errors++; $display("FAIL deep_req got st=%0d ds=%b ls=%b exp st=2 ds=1 ls=0", d_pwr_state, dut_d.ds_req, dut_d.ls_req); end
    irq_wake = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (d_pwr_state !== 2'd3 || d_ready !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL deep_wake_len got %0d bad cycles exp 0", bad); end
    tick();
    checks++; if (d_pwr_state !== 2'd0) begin errors++; $display("FAIL deep_active got %0d exp 0", d_pwr_state); end
    wfi = 1'b0; irq_wake = 1'b0; req = 1'b1; addr = 32'h14;
    tick();
    checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL deep_fetch got v=%b %h exp v=1 deadbeef", d_rvalid, d_rdata); end
    req = 1'b0;
  endtask

  task automatic test_reset_mid_wake();
    pulse_reset();
    go_deep();
    irq_wake = 1'b1;
    tick();
    tick();
    checks++; if (d_pwr_state !== 2'd3) begin errors++; $display("FAIL rst_wake_pre got %0d exp 3", d_pwr_state); end
    rst = 1'b1; irq_wake = 1'b0; wfi = 1'b0;
    tick();
    checks++; if (d_pwr_state !== 2'd0 || d_rvalid !== 1'b0) begin errors++; $display("FAIL rst_wake_state got st=%0d v=%b exp st=0 v=0", d_pwr_state, d_rvalid); end
    rst = 1'b0; req = 1'b1; addr = 32'h0001_0000;
    tick();
    checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h12345678) begin errors++; $display("FAIL rst_wake_fetch got v=%b %h exp v=1 12345678", d_rvalid, d_rdata); end
    req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = 1'b0; addr = '0; wfi = 1'b0; irq_wake = 1'b0;
    preload();
    test_reset();
    test_back_to_back();
    test_out_of_range();
    test_standby();
    test_wfi_fetch();
    test_deep();
    test_reset_mid_wake();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
